// File: rtl/ram_result_reader_pkg.sv
// ram_result_reader_pkg: shared lab constants for the RAM result reader.
package ram_result_reader_pkg;
    localparam int DATA_W_DEF = 8;
    localparam int ADR_W_DEF  = 4;
    localparam logic [3:0] ST_IDLE  = 4'd0;
    localparam logic [3:0] ST_ISSUE = 4'd1;
    localparam logic [3:0] ST_WAIT  = 4'd2;
    localparam logic [3:0] ST_HOLD  = 4'd3;
    localparam logic [3:0] ST_DONE  = 4'd4;
endpackage

// File: rtl/ram_result_reader.sv
// ram_result_reader: bursts words out of a synchronous-read RAM into a valid/ready consumer.
import ram_result_reader_pkg::*;

module ram_result_reader #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADR_W  = ADR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADR_W-1:0]  base_adr,
    input  logic [ADR_W:0]    count,
    output logic              ram_en,
    output logic [ADR_W-1:0]  ram_adr,
    input  logic [DATA_W-1:0] ram_dout,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    input  logic              data_ready,
    output logic              busy,
    output logic              done,
    output logic [3:0]        st_out
);
    logic [3:0]        st_q, st_d;
    logic [ADR_W-1:0]  adr_q, adr_d;
    logic [ADR_W:0]    rem_q, rem_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              hs;

    assign hs = valid_q & data_ready;

    always_comb begin
        st_d    = st_q;
        adr_d   = adr_q;
        rem_d   = rem_q;
        data_d  = data_q;
        valid_d = valid_q;
        case (st_q)
            ST_IDLE: if (start) begin
                st_d  = (count != '0) ? ST_ISSUE : ST_DONE;
                adr_d = (count != '0) ? base_adr : adr_q;
                rem_d = count;
            end
            ST_ISSUE: st_d = ST_WAIT;
            ST_WAIT: begin
                data_d  = ram_dout;
                valid_d = 1'b1;
                st_d    = ST_HOLD;
            end
            ST_HOLD: if (hs) begin
                // the last word leaves the address where it was; only a following word advances it
                valid_d = 1'b0;
                rem_d   = rem_q - 1'b1;
                st_d    = (rem_q == (ADR_W+1)'(1)) ? ST_DONE : ST_ISSUE;
                adr_d   = (rem_q == (ADR_W+1)'(1)) ? adr_q : adr_q + 1'b1;
            end
            ST_DONE: st_d = ST_IDLE;
            default: st_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q    <= ST_IDLE;
            adr_q   <= '0;
            rem_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            st_q    <= st_d;
            adr_q   <= adr_d;
            rem_q   <= rem_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign ram_en     = (st_q == ST_ISSUE);
    assign ram_adr    = adr_q;
    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign busy       = (st_q != ST_IDLE);
    assign done       = (st_q == ST_DONE);
    assign st_out     = st_q;
endmodule

// File: tb/tb_ram_result_reader.sv
// tb_ram_result_reader: randomized and directed bursts checked against a queue-based reference.
module tb_ram_result_reader;
    localparam int DW = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_adr = '0;
    logic [AW:0]   count = '0;
    logic          ram_en;
    logic [AW-1:0] ram_adr;
    logic [DW-1:0] ram_dout = '0;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic          data_ready = 1'b0;
    logic          busy;
    logic          done;
    logic [3:0]    st_out;

    ram_result_reader dut (
        .clk(clk), .rst(rst), .start(start), .base_adr(base_adr), .count(count),
        .ram_en(ram_en), .ram_adr(ram_adr), .ram_dout(ram_dout),
        .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
        .busy(busy), .done(done), .st_out(st_out)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [16];
    always @(posedge clk) if (ram_en) ram_dout <= mem[ram_adr];

    int checks = 0;
    int fails  = 0;
    int words  = 0;
    bit rand_ready  = 1'b0;
    bit ready_force = 1'b1;

    always @(posedge clk) begin
        #1 data_ready = rand_ready ? ($urandom_range(0, 1) == 1) : ready_force;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        fails++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // reference: a burst is just the list of addresses and words it must produce
    logic [AW-1:0] exp_adr [$];
    logic [DW-1:0] exp_data [$];
    bit active = 0, done_due = 0, done_next, pv = 0, pr = 0, en1 = 0, en2 = 0;
    logic [DW-1:0] pd = '0;

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_outs", 32'({ram_en, ram_adr, data_out, data_valid, busy, done, st_out}), 0);
            exp_adr.delete();
            exp_data.delete();
            active = 0; done_due = 0; pv = 0; pr = 0; en1 = 0; en2 = 0;
        end else begin
            done_next = 0;
            chk("busy", 32'(busy), 32'(active));
            chk("st_idle", 32'(st_out == 0), 32'(!active));
            chk("done", 32'(done), 32'(done_due));
            chk("new_word", 32'(data_valid && !(pv && !pr)), 32'(en2));
            if (pv && !pr) begin
                chk("hold_valid", 32'(data_valid), 1);
                chk("hold_data", 32'(data_out), 32'(pd));
            end
            if (start && !active) begin
                active = 1;
                for (int i = 0; i < int'(count); i++) begin
                    exp_adr.push_back(AW'(int'(base_adr) + i));
                    exp_data.push_back(mem[(int'(base_adr) + i) % 16]);
                end
                if (count == 0) done_next = 1;
            end
            if (ram_en) begin
                chk("en_in_hold", 32'(data_valid), 0);
                if (exp_adr.size() == 0) flag("en_extra");
                else chk("ram_adr", 32'(ram_adr), 32'(exp_adr.pop_front()));
            end
            if (data_valid && data_ready) begin
                words++;
                if (exp_data.size() == 0) flag("word_extra");
                else begin
                    chk("data_out", 32'(data_out), 32'(exp_data.pop_front()));
                    if (exp_data.size() == 0) done_next = 1;
                end
            end
            if (done_due) active = 0;
            done_due = done_next;
            en2 = en1; en1 = ram_en;
            pv = data_valid; pr = data_ready; pd = data_out;
        end
    end

    task automatic start_burst(input int b, input int c);
        @(posedge clk);
        #1 start = 1'b1; base_adr = AW'(b); count = (AW+1)'(c);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || active) && n < 3000) begin
            @(posedge clk); #2; n++;
        end
        if (n >= 3000) flag("idle_timeout");
    endtask

    task automatic wait_words(input int target);
        int n = 0;
        while (words < target && n < 500) begin
            @(posedge clk); #2; n++;
        end
        if (n >= 500) flag("words_timeout");
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!data_valid && n < 50) begin
            @(posedge clk); #2; n++;
        end
        if (n >= 50) flag("valid_timeout");
    endtask

    int w0;

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = DW'($urandom);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        chk("reset_st", 32'(st_out), 0);
        chk("reset_adr", 32'(ram_adr), 0);

        // single word, latency pinned by hand
        mem[0] = 8'h0C;
        ready_force = 1'b1;
        start_burst(0, 1);
        @(negedge clk); chk("lat_en", 32'(ram_en), 1); chk("lat_adr", 32'(ram_adr), 0);
        @(negedge clk); chk("lat_en_off", 32'(ram_en), 0); chk("lat_valid_early", 32'(data_valid), 0);
        @(negedge clk); chk("lat_valid", 32'(data_valid), 1); chk("lat_data", 32'(data_out), 32'h0C);
        @(negedge clk); chk("lat_done", 32'(done), 1);
        @(negedge clk); chk("lat_st_back", 32'(st_out), 0); chk("lat_done_off", 32'(done), 0);

        // empty burst goes straight to DONE
        start_burst(3, 0);
        @(negedge clk);
        chk("zero_done", 32'(done), 1); chk("zero_st", 32'(st_out), 4);
        chk("zero_en", 32'(ram_en), 0); chk("zero_valid", 32'(data_valid), 0);
        @(negedge clk); chk("zero_idle", 32'(st_out), 0);

        // wrapping burst
        mem[14] = 8'h10; mem[15] = 8'h20; mem[0] = 8'h30;
        w0 = words;
        start_burst(14, 3);
        wait_idle();
        chk("wrap_words", 32'(words - w0), 3);

        // same burst with the consumer stalling on the second word
        w0 = words;
        start_burst(14, 3);
        wait_words(w0 + 1);
        ready_force = 1'b0;
        repeat (8) @(posedge clk);
        #2 chk("stall_valid", 32'(data_valid), 1); chk("stall_data", 32'(data_out), 32'h20);
        ready_force = 1'b1;
        wait_idle();
        chk("stall_words", 32'(words - w0), 3);

        // restart while busy is ignored
        w0 = words;
        start_burst(2, 4);
        repeat (4) @(posedge clk);
        start_burst(9, 5);
        wait_idle();
        chk("ignore_words", 32'(words - w0), 4);

        // reset in HOLD of word 3 of a 16-word burst
        w0 = words;
        start_burst(5, 16);
        wait_words(w0 + 2);
        ready_force = 1'b0;
        wait_valid();
        rst = 1'b1;
        #1 chk("async_rst", 32'({ram_en, ram_adr, data_out, data_valid, busy, done, st_out}), 0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        ready_force = 1'b1;
        repeat (3) @(posedge clk);
        #2 chk("no_resume", 32'(st_out), 0);
        w0 = words;
        start_burst(0, 2);
        wait_idle();
        chk("post_rst_words", 32'(words - w0), 2);

        // randomized bursts, random back-pressure and stray starts
        rand_ready = 1'b1;
        for (int k = 0; k < 25; k++) begin
            if ($urandom_range(0, 1) == 1)
                for (int i = 0; i < 16; i++) mem[i] = DW'($urandom);
            start_burst(int'($urandom_range(0, 15)), int'($urandom_range(0, 16)));
            repeat ($urandom_range(0, 10)) @(posedge clk);
            if ($urandom_range(0, 1) == 1)
                start_burst(int'($urandom_range(0, 15)), int'($urandom_range(0, 16)));
            wait_idle();
        end
        rand_ready = 1'b0;
        repeat (3) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
